regfile_dbg_master: RTL and testbench
=====================================

Name: regfile_dbg_master

Overview:
Debug-side initiator for the CPU register file. It drives the file's read/write port (rs1/rs2/rd/re/we/data) and captures the one-cycle-latency read values. It accepts host commands over a valid/ready channel: single read, single write, full dump or clear. Results return over a valid/ready response channel. It sits between the debug module and the register file and is active only while the core is halted.

Parameters:
XLEN, 32, data width of a register
NREGS, 32, number of architectural registers (power of two)
AW, 5, register index width, log2(NREGS)

Ports:
I_clk  in  1  clock, rising edge
I_rst_n  in  1  synchronous active-low reset
I_halted  in  1  core halted; register file free for debug access
I_cmd_valid  in  1  command valid
O_cmd_ready  out  1  command accepted when valid&ready
I_cmd_op  in  2  00 READ, 01 WRITE, 10 DUMP, 11 CLEAR
I_cmd_addr  in  AW  register index (READ/WRITE)
I_cmd_wdata  in  XLEN  write data (WRITE)
O_rsp_valid  out  1  response valid
I_rsp_ready  in  1  response consumed when valid&ready
O_rsp_addr  out  AW  register index of response
O_rsp_data  out  XLEN  read data (0 for WRITE/CLEAR)
O_rsp_err  out  1  error flag
O_busy  out  1  command in progress (not IDLE)
O_rs1, O_rs2, O_rd  out  AW  register file indices
O_re, O_we  out  1  register file read/write enables
O_data  out  XLEN  register file write data
I_regval1, I_regval2  in  XLEN  register file read data, valid the cycle after O_re

Behaviour:
- Reset (I_rst_n=0 at edge): state IDLE; all outputs 0, including ready, valid, enables, indices and data.
- O_cmd_ready = (state==IDLE) & I_halted. Command latched on the accepting edge.
- O_re and O_we are 1-cycle pulses. O_we is never asserted with O_rd==0.
- States: IDLE, WR, RD, RDW, DMP, DMPW, RSP0, RSP1, CLR.
- WRITE: next cycle (WR): O_we=1, O_rd=addr, O_data=wdata. Then RSP0 with data=0, err=0. If addr==0: no O_we; response err=1.
- READ: RD: O_re=1, O_rs1=addr. RDW captures I_regval1. RSP0 returns data, err=0. Latency from accept to O_rsp_valid: 3 cycles.
- DUMP: a pair counter p runs from 0 to NREGS/2-1.
  - DMP: O_re=1, O_rs1=2p, O_rs2=2p+1.
  - DMPW: capture both values.
  - RSP0 emits (2p, val1); RSP1 emits (2p+1, val2).
  - After the last pair, return to IDLE.
  - Output is NREGS responses in ascending index order.
- CLEAR: CLR writes 0 to x1..x(NREGS-1), one per cycle (O_we=1, O_data=0), then one response with addr=NREGS-1, data=0, err=0.
- Backpressure: while O_rsp_valid & !I_rsp_ready, addr/data/err hold stable and the FSM stalls; no regfile access is issued. Handshake advances on the same edge. After the final response, IDLE; O_cmd_ready may be 1 on the next cycle.
- Halt loss: if I_halted=0 in DMP or CLR, no new regfile access is issued.
  - Emit one response: addr = next unprocessed index, data=0, err=1. Then IDLE.
  - Responses already captured (RSP0/RSP1) are delivered first. Single READ/WRITE complete regardless.
- Mid-operation reset: immediate return to IDLE. Pending response dropped; partial CLEAR not rolled back.
- Counter arithmetic is AW bits. The pair index never wraps past NREGS/2-1.

Optional Feature:
REGDBG_DUMP_EN
- Defined: DUMP behaves as above.
- Undefined: DMP/DMPW/RSP1 logic and the pair counter are omitted. DUMP is accepted and answered with a single response, addr=0, data=0, err=1, 1 cycle after accept. No regfile access.

Test Plan:
- Halted=1, WRITE addr=5 wdata=0xDEADBEEF, then READ addr=5 -> O_we pulse with rd=5; read response addr=5 data=0xDEADBEEF err=0, valid 3 cycles after accept.
- WRITE addr=0 data=0x1234 -> no O_we pulse; response err=1; later READ addr=0 returns 0.
- Preload x_i=i*0x11, DUMP with I_rsp_ready toggling every other cycle -> 32 responses addr 0..31, data i*0x11, stable under stall. (Undefined macro: one err=1 response.)
- CLEAR after preload -> 31 consecutive O_we pulses rd=1..31 data=0; one response addr=31; subsequent DUMP all zeros.
- DUMP, drop I_halted after pair 3 issued -> pairs 0..3 delivered (8 responses), then err=1 response addr=8; no further O_re.
- I_rst_n=0 during CLEAR at x10 -> next cycle all outputs 0, state IDLE; x1..x9 read back 0, x10+ unchanged.

Source files
------------

// File: rtl/regfile_dbg_master.sv
// Debug-side register file initiator: READ/WRITE/DUMP/CLEAR over valid/ready while the core is halted.
// Define REGDBG_DUMP_EN to build the pair-wise DUMP engine; otherwise DUMP answers with an error response.
module regfile_dbg_master #(
  parameter int unsigned XLEN  = 32,
  parameter int unsigned NREGS = 32,
  parameter int unsigned AW    = 5
) (
  input  logic            I_clk,
  input  logic            I_rst_n,
  input  logic            I_halted,
  input  logic            I_cmd_valid,
  output logic            O_cmd_ready,
  input  logic [1:0]      I_cmd_op,
  input  logic [AW-1:0]   I_cmd_addr,
  input  logic [XLEN-1:0] I_cmd_wdata,
  output logic            O_rsp_valid,
  input  logic            I_rsp_ready,
  output logic [AW-1:0]   O_rsp_addr,
  output logic [XLEN-1:0] O_rsp_data,
  output logic            O_rsp_err,
  output logic            O_busy,
  output logic [AW-1:0]   O_rs1,
  output logic [AW-1:0]   O_rs2,
  output logic [AW-1:0]   O_rd,
  output logic            O_re,
  output logic            O_we,
  output logic [XLEN-1:0] O_data,
  input  logic [XLEN-1:0] I_regval1,
  input  logic [XLEN-1:0] I_regval2
);

  localparam logic [1:0]    OP_READ  = 2'b00;
  localparam logic [1:0]    OP_WRITE = 2'b01;
  localparam logic [1:0]    OP_DUMP  = 2'b10;
  localparam logic [AW-1:0] LAST_IDX = AW'(NREGS - 1);

  typedef enum logic [3:0] {
    ST_IDLE, ST_WR, ST_RD, ST_RDW, ST_DMP, ST_DMPW, ST_RSP0, ST_RSP1, ST_CLR
  } state_e;

  state_e          state_q, state_d;
  logic            idle_q, busy_q;
  logic [AW-1:0]   idx_q, idx_d;
  logic            rsp_valid_q, rsp_valid_d;
  logic [AW-1:0]   rsp_addr_q, rsp_addr_d;
  logic [XLEN-1:0] rsp_data_q, rsp_data_d;
  logic            rsp_err_q, rsp_err_d;
  logic [AW-1:0]   rs1_q, rs1_d;
  logic [AW-1:0]   rd_q, rd_d;
  logic [XLEN-1:0] wdata_q, wdata_d;
  logic            re_q, re_d;
  logic            we_q, we_d;
  logic            cmd_accept_c;

`ifdef REGDBG_DUMP_EN
  localparam logic [AW-1:0] LAST_PAIR = AW'(NREGS / 2 - 1);
  logic [1:0]      op_q, op_d;
  logic [AW-1:0]   pair_q, pair_d;
  logic [AW-1:0]   rs2_q, rs2_d;
  logic [XLEN-1:0] val2_q, val2_d;
  assign O_rs2 = rs2_q;
`else
  logic unused_regval2;
  assign unused_regval2 = ^I_regval2;
  assign O_rs2 = '0;
`endif

  // idle_q is cleared by reset so ready stays low while reset is applied
  assign O_cmd_ready  = idle_q & I_halted;
  assign cmd_accept_c = I_cmd_valid & O_cmd_ready;

  assign O_rsp_valid = rsp_valid_q;
  assign O_rsp_addr  = rsp_addr_q;
  assign O_rsp_data  = rsp_data_q;
  assign O_rsp_err   = rsp_err_q;
  assign O_busy      = busy_q;
  assign O_rs1       = rs1_q;
  assign O_rd        = rd_q;
  assign O_re        = re_q;
  assign O_we        = we_q;
  assign O_data      = wdata_q;

  // Next-state and next-output logic
  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    rsp_valid_d = rsp_valid_q;
    rsp_addr_d  = rsp_addr_q;
    rsp_data_d  = rsp_data_q;
    rsp_err_d   = rsp_err_q;
    rs1_d       = rs1_q;
    rd_d        = rd_q;
    wdata_d     = wdata_q;
    re_d        = 1'b0;
    we_d        = 1'b0;
`ifdef REGDBG_DUMP_EN
    op_d        = op_q;
    pair_d      = pair_q;
    rs2_d       = rs2_q;
    val2_d      = val2_q;
`endif
    case (state_q)
      ST_IDLE: begin
        if (cmd_accept_c) begin
`ifdef REGDBG_DUMP_EN
          op_d = I_cmd_op;
`endif
          rsp_addr_d = I_cmd_addr;
          rsp_data_d = '0;
          rsp_err_d  = 1'b0;
          case (I_cmd_op)
            OP_READ: begin
              state_d = ST_RD;
              re_d    = 1'b1;
              rs1_d   = I_cmd_addr;
            end
            OP_WRITE: begin
              state_d   = ST_WR;
              we_d      = (I_cmd_addr != '0);
              rd_d      = I_cmd_addr;
              wdata_d   = I_cmd_wdata;
              rsp_err_d = (I_cmd_addr == '0);
            end
            OP_DUMP: begin
`ifdef REGDBG_DUMP_EN
              state_d = ST_DMP;
              re_d    = 1'b1;
              pair_d  = '0;
              rs1_d   = '0;
              rs2_d   = AW'(1);
`else
              state_d     = ST_RSP0;
              rsp_valid_d = 1'b1;
              rsp_addr_d  = '0;
              rsp_err_d   = 1'b1;
`endif
            end
            default: begin
              state_d = ST_CLR;
              we_d    = 1'b1;
              rd_d    = AW'(1);
              wdata_d = '0;
              idx_d   = AW'(1);
            end
          endcase
        end
      end
      ST_WR: begin
        state_d     = ST_RSP0;
        rsp_valid_d = 1'b1;
      end
      ST_RD: state_d = ST_RDW;
      ST_RDW: begin
        state_d     = ST_RSP0;
        rsp_valid_d = 1'b1;
        rsp_data_d  = I_regval1;
      end
      // idx_q is the register written this cycle; halt loss reports the next one
      ST_CLR: begin
        if (idx_q == LAST_IDX) begin
          state_d     = ST_RSP0;
          rsp_valid_d = 1'b1;
          rsp_addr_d  = LAST_IDX;
          rsp_data_d  = '0;
          rsp_err_d   = 1'b0;
        end else if (I_halted) begin
          we_d  = 1'b1;
          rd_d  = idx_q + AW'(1);
          idx_d = idx_q + AW'(1);
        end else begin
          state_d     = ST_RSP0;
          rsp_valid_d = 1'b1;
          rsp_addr_d  = idx_q + AW'(1);
          rsp_data_d  = '0;
          rsp_err_d   = 1'b1;
        end
      end
      ST_RSP0: begin
        if (I_rsp_ready) begin
          state_d     = ST_IDLE;
          rsp_valid_d = 1'b0;
`ifdef REGDBG_DUMP_EN
          if (op_q == OP_DUMP && !rsp_err_q) begin
            state_d     = ST_RSP1;
            rsp_valid_d = 1'b1;
            rsp_addr_d  = rs2_q;
            rsp_data_d  = val2_q;
          end
`endif
        end
      end
`ifdef REGDBG_DUMP_EN
      ST_DMP: state_d = ST_DMPW;
      ST_DMPW: begin
        state_d     = ST_RSP0;
        rsp_valid_d = 1'b1;
        rsp_addr_d  = rs1_q;
        rsp_data_d  = I_regval1;
        rsp_err_d   = 1'b0;
        val2_d      = I_regval2;
      end
      // Next pair is only issued while halted; otherwise report its even index as an error
      ST_RSP1: begin
        if (I_rsp_ready) begin
          if (pair_q == LAST_PAIR) begin
            state_d     = ST_IDLE;
            rsp_valid_d = 1'b0;
          end else if (I_halted) begin
            state_d     = ST_DMP;
            rsp_valid_d = 1'b0;
            re_d        = 1'b1;
            pair_d      = pair_q + AW'(1);
            rs1_d       = rs1_q + AW'(2);
            rs2_d       = rs2_q + AW'(2);
          end else begin
            state_d    = ST_RSP0;
            rsp_addr_d = rs1_q + AW'(2);
            rsp_data_d = '0;
            rsp_err_d  = 1'b1;
          end
        end
      end
`endif
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge I_clk) begin
    if (!I_rst_n) begin
      state_q     <= ST_IDLE;
      idle_q      <= 1'b0;
      busy_q      <= 1'b0;
      idx_q       <= '0;
      rsp_valid_q <= 1'b0;
      rsp_addr_q  <= '0;
      rsp_data_q  <= '0;
      rsp_err_q   <= 1'b0;
      rs1_q       <= '0;
      rd_q        <= '0;
      wdata_q     <= '0;
      re_q        <= 1'b0;
      we_q        <= 1'b0;
`ifdef REGDBG_DUMP_EN
      op_q        <= '0;
      pair_q      <= '0;
      rs2_q       <= '0;
      val2_q      <= '0;
`endif
    end else begin
      state_q     <= state_d;
      idle_q      <= (state_d == ST_IDLE);
      busy_q      <= (state_d != ST_IDLE);
      idx_q       <= idx_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_addr_q  <= rsp_addr_d;
      rsp_data_q  <= rsp_data_d;
      rsp_err_q   <= rsp_err_d;
      rs1_q       <= rs1_d;
      rd_q        <= rd_d;
      wdata_q     <= wdata_d;
      re_q        <= re_d;
      we_q        <= we_d;
`ifdef REGDBG_DUMP_EN
      op_q        <= op_d;
      pair_q      <= pair_d;
      rs2_q       <= rs2_d;
      val2_q      <= val2_d;
`endif
    end
  end

endmodule

// File: tb/tb_regfile_dbg_master.sv
// Bench for regfile_dbg_master: behavioural register file, scoreboard of expected responses.
// Follows REGDBG_DUMP_EN for the DUMP-specific sequences.
module tb_regfile_dbg_master;

  localparam int unsigned XLEN  = 32;
  localparam int unsigned NREGS = 32;
  localparam int unsigned AW    = 5;
  localparam logic [1:0] OP_READ  = 2'b00;
  localparam logic [1:0] OP_WRITE = 2'b01;
  localparam logic [1:0] OP_DUMP  = 2'b10;
  localparam logic [1:0] OP_CLEAR = 2'b11;

  typedef struct packed {
    logic [AW-1:0]   addr;
    logic [XLEN-1:0] data;
    logic            err;
  } rsp_t;

  logic            I_clk = 1'b0;
  logic            I_rst_n = 1'b0;
  logic            I_halted = 1'b1;
  logic            I_cmd_valid = 1'b0;
  logic [1:0]      I_cmd_op = 2'b00;
  logic [AW-1:0]   I_cmd_addr = '0;
  logic [XLEN-1:0] I_cmd_wdata = '0;
  logic            I_rsp_ready = 1'b0;
  logic            O_cmd_ready, O_rsp_valid, O_rsp_err, O_busy, O_re, O_we;
  logic [AW-1:0]   O_rsp_addr, O_rs1, O_rs2, O_rd;
  logic [XLEN-1:0] O_rsp_data, O_data;
  logic [XLEN-1:0] rv1 = '0;
  logic [XLEN-1:0] rv2 = '0;
  logic [XLEN-1:0] mem [NREGS] = '{default: '0};
  logic [XLEN-1:0] exp_mem [NREGS];
  rsp_t            exp_q [$];
  int              re_cnt = 0;
  int              we0_cnt = 0;
  int              total = 0;
  int              bad = 0;

  regfile_dbg_master #(.XLEN(XLEN), .NREGS(NREGS), .AW(AW)) dut (
    .I_clk(I_clk), .I_rst_n(I_rst_n), .I_halted(I_halted),
    .I_cmd_valid(I_cmd_valid), .O_cmd_ready(O_cmd_ready), .I_cmd_op(I_cmd_op),
    .I_cmd_addr(I_cmd_addr), .I_cmd_wdata(I_cmd_wdata),
    .O_rsp_valid(O_rsp_valid), .I_rsp_ready(I_rsp_ready), .O_rsp_addr(O_rsp_addr),
    .O_rsp_data(O_rsp_data), .O_rsp_err(O_rsp_err), .O_busy(O_busy),
    .O_rs1(O_rs1), .O_rs2(O_rs2), .O_rd(O_rd), .O_re(O_re), .O_we(O_we),
    .O_data(O_data), .I_regval1(rv1), .I_regval2(rv2)
  );

  always #5 I_clk = ~I_clk;

  // Register file with one-cycle read latency
  always @(posedge I_clk) begin
    if (O_we) mem[O_rd] <= O_data;
    if (O_we && O_rd == '0) we0_cnt <= we0_cnt + 1;
    if (O_re) begin
      re_cnt <= re_cnt + 1;
      rv1    <= mem[O_rs1];
      rv2    <= mem[O_rs2];
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog timeout total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge I_clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic rsp_t mk(input int addr, input logic [XLEN-1:0] data, input logic err);
    rsp_t r;
    r.addr = AW'(addr);
    r.data = data;
    r.err  = err;
    return r;
  endfunction

  task automatic send(input logic [1:0] op, input logic [AW-1:0] addr, input logic [XLEN-1:0] wd);
    int n;
    n = 0;
    I_cmd_valid = 1'b1;
    I_cmd_op    = op;
    I_cmd_addr  = addr;
    I_cmd_wdata = wd;
    while (O_cmd_ready !== 1'b1 && n < 64) begin tick(); n++; end
    chk("cmd_ready", 128'(O_cmd_ready), 128'(1));
    tick();
    I_cmd_valid = 1'b0;
  endtask

  // Waits for a response, holds ready low for `stall` cycles, then handshakes; lat counts the accept edge
  task automatic get_rsp(input string tag, input int stall, output int lat);
    rsp_t e;
    int n;
    n = 0;
    while (O_rsp_valid !== 1'b1 && n < 200) begin tick(); n++; end
    lat = n + 1;
    chk({tag, "_sb"}, 128'(exp_q.size() > 0), 128'(1));
    e = (exp_q.size() > 0) ? exp_q.pop_front() : mk(0, '0, 1'b0);
    for (int s = 0; s <= stall; s++) begin
      chk($sformatf("%s_a%0d_s%0d", tag, e.addr, s),
          128'({O_rsp_valid, O_rsp_addr, O_rsp_data, O_rsp_err}),
          128'({1'b1, e.addr, e.data, e.err}));
      if (s == stall) I_rsp_ready = 1'b1;
      tick();
    end
    I_rsp_ready = 1'b0;
  endtask

  task automatic readback(input string tag);
    int lat;
    for (int i = 0; i < NREGS; i++) begin
      exp_q.push_back(mk(i, exp_mem[i], 1'b0));
      send(OP_READ, AW'(i), '0);
      get_rsp(tag, i % 2, lat);
    end
  endtask

  task automatic preload(input logic [XLEN-1:0] mult);
    int lat;
    for (int i = 1; i < NREGS; i++) begin
      exp_mem[i] = XLEN'(i) * mult;
      exp_q.push_back(mk(i, '0, 1'b0));
      send(OP_WRITE, AW'(i), exp_mem[i]);
      get_rsp("pre", 0, lat);
    end
  endtask

`ifdef REGDBG_DUMP_EN
  task automatic dump_all(input string tag);
    int lat;
    for (int i = 0; i < NREGS; i++) exp_q.push_back(mk(i, exp_mem[i], 1'b0));
    send(OP_DUMP, '0, '0);
    for (int i = 0; i < NREGS; i++) get_rsp(tag, 1, lat);
  endtask
`endif

  initial begin
    int lat;
    int re0;
    int n;
    for (int i = 0; i < NREGS; i++) exp_mem[i] = '0;

    // Reset state
    repeat (2) tick();
    chk("rst_outs", 128'({O_cmd_ready, O_rsp_valid, O_rsp_addr, O_rsp_data, O_rsp_err, O_busy,
                          O_rs1, O_rs2, O_rd, O_re, O_we, O_data}), 128'(0));
    I_rst_n = 1'b1;
    tick();
    chk("idle_ready", 128'({O_cmd_ready, O_busy}), 128'({1'b1, 1'b0}));

    // WRITE x5 then READ x5
    exp_q.push_back(mk(5, '0, 1'b0));
    send(OP_WRITE, 5'd5, 32'hDEADBEEF);
    chk("wr_pulse", 128'({O_we, O_rd, O_data, O_busy}), 128'({1'b1, 5'd5, 32'hDEADBEEF, 1'b1}));
    exp_mem[5] = 32'hDEADBEEF;
    get_rsp("wr5", 2, lat);
    chk("wr_lat", 128'(lat), 128'(2));
    exp_q.push_back(mk(5, 32'hDEADBEEF, 1'b0));
    send(OP_READ, 5'd5, '0);
    chk("rd_issue", 128'({O_re, O_rs1, O_we}), 128'({1'b1, 5'd5, 1'b0}));
    get_rsp("rd5", 0, lat);
    chk("rd_lat", 128'(lat), 128'(3));

    // WRITE x0 is refused with an error; x0 reads back 0
    exp_q.push_back(mk(0, '0, 1'b1));
    send(OP_WRITE, 5'd0, 32'h1234);
    chk("wr0_nowe", 128'(O_we), 128'(0));
    get_rsp("wr0", 1, lat);
    exp_q.push_back(mk(0, '0, 1'b0));
    send(OP_READ, 5'd0, '0);
    get_rsp("rd0", 0, lat);

    // DUMP of preloaded file
    preload(32'h11);
`ifdef REGDBG_DUMP_EN
    dump_all("dump");
`else
    exp_q.push_back(mk(0, '0, 1'b1));
    send(OP_DUMP, '0, '0);
    chk("dump_noread", 128'(O_re), 128'(0));
    get_rsp("dump_err", 1, lat);
    chk("dump_lat", 128'(lat), 128'(1));
    readback("rdb");
`endif

    // CLEAR: 31 back-to-back writes of zero, one response for the last index
    exp_q.push_back(mk(NREGS - 1, '0, 1'b0));
    send(OP_CLEAR, '0, '0);
    for (int i = 1; i < NREGS; i++) begin
      chk($sformatf("clr_we%0d", i), 128'({O_we, O_rd, O_data}), 128'({1'b1, AW'(i), 32'h0}));
      tick();
    end
    chk("clr_done_we", 128'(O_we), 128'(0));
    get_rsp("clr", 1, lat);
    for (int i = 1; i < NREGS; i++) exp_mem[i] = '0;
`ifdef REGDBG_DUMP_EN
    dump_all("dump0");

    // Halt loss during DUMP after pair 3 is issued
    preload(32'h101);
    re0 = re_cnt;
    for (int i = 0; i < 8; i++) exp_q.push_back(mk(i, exp_mem[i], 1'b0));
    exp_q.push_back(mk(8, '0, 1'b1));
    send(OP_DUMP, '0, '0);
    for (int i = 0; i < 6; i++) get_rsp("hl", 1, lat);
    chk("hl_pair3", 128'({O_re, O_rs1, O_rs2}), 128'({1'b1, 5'd6, 5'd7}));
    I_halted = 1'b0;
    for (int i = 0; i < 3; i++) get_rsp("hl_tail", 1, lat);
    repeat (4) tick();
    chk("hl_re_cnt", 128'(re_cnt - re0), 128'(4));
    chk("hl_idle", 128'({O_busy, O_cmd_ready, O_rsp_valid}), 128'(0));
    I_halted = 1'b1;
`else
    readback("rdb0");
    preload(32'h101);
`endif

    // Reset while CLEAR is about to write x10
    send(OP_CLEAR, '0, '0);
    n = 0;
    while (!(O_we === 1'b1 && O_rd === 5'd9) && n < 64) begin tick(); n++; end
    chk("rst_clr_at9", 128'({O_we, O_rd}), 128'({1'b1, 5'd9}));
    I_rst_n = 1'b0;
    tick();
    chk("mid_rst_outs", 128'({O_cmd_ready, O_rsp_valid, O_rsp_addr, O_rsp_data, O_rsp_err, O_busy,
                              O_rs1, O_rs2, O_rd, O_re, O_we, O_data}), 128'(0));
    I_rst_n = 1'b1;
    tick();
    for (int i = 1; i < 10; i++) exp_mem[i] = '0;
    readback("post_rst");

    repeat (3) tick();
    chk("no_rsp_left", 128'(O_rsp_valid), 128'(0));
    chk("sb_empty", 128'(exp_q.size()), 128'(0));
    chk("no_x0_write", 128'(we0_cnt), 128'(0));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
